// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID read master: FSM states, slave word
// addresses and the default build-time expected values.
package sysid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1380147445;

endpackage

// File: rtl/avm_read_port.sv
// Single Avalon-MM read handshake with a per-read stall timeout.
// A read is offered while req=1 and completes (ack) on the first cycle the
// slave drops waitrequest; req/addr must stay stable until ack or timeout.
module avm_read_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        addr,
  output logic        ack,
  output logic [31:0] data,
  output logic        timeout,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_cnt;

  assign avm_read    = req;
  assign avm_address = addr;
  assign ack         = req && !avm_waitrequest;
  assign data        = avm_readdata;
  assign timeout     = req && avm_waitrequest && (wait_cnt == TIMEOUT_LIMIT);

  // Counts stalled cycles of the current read; saturates instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || !req || ack) begin
      wait_cnt <= 16'd0;
    end else if (avm_waitrequest && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sysid_read_master.sv
// Reads the sysid ID and timestamp words after a start pulse and flags any
// mismatch against the build-time expected values.
module sysid_read_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  state_dbg
);

  sysid_state_e state;
  logic         rd_req;
  logic         rd_addr;
  logic         rd_ack;
  logic         rd_timeout;
  logic [31:0]  rd_data;

  assign state_dbg = state;

  avm_read_port #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clock           (clock),
    .reset           (reset),
    .req             (rd_req),
    .addr            (rd_addr),
    .ack             (rd_ack),
    .data            (rd_data),
    .timeout         (rd_timeout),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rd_req      <= 1'b0;
      rd_addr     <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_id      <= 1'b0;
      err_ts      <= 1'b0;
      err_timeout <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_ID;
            rd_req      <= 1'b1;
            rd_addr     <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_id      <= 1'b0;
            err_ts      <= 1'b0;
            err_timeout <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
          end
        end
        RD_ID: begin
          if (rd_timeout) begin
            err_timeout <= 1'b1;
            rd_req      <= 1'b0;
            state       <= FINISH;
          end else if (rd_ack) begin
            // Keep read asserted and move straight to the timestamp word.
            id_value <= rd_data;
            err_id   <= (rd_data != EXPECTED_ID);
            rd_addr  <= SYSID_ADDR_TS;
            state    <= RD_TS;
          end
        end
        RD_TS: begin
          if (rd_timeout) begin
            err_timeout <= 1'b1;
            rd_req      <= 1'b0;
            state       <= FINISH;
          end else if (rd_ack) begin
            ts_value <= rd_data;
            err_ts   <= (rd_data != EXPECTED_TIMESTAMP);
            rd_req   <= 1'b0;
            rd_addr  <= SYSID_ADDR_ID;
            state    <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= !err_timeout && !err_id && !(CHECK_TIMESTAMP && err_ts);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_read_master.sv
// Directed bench: two masters (timestamp checked / not checked) share one
// sysid slave model with programmable stall length.
module tb_sysid_read_master;
  import sysid_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] id_word;
  logic [31:0] ts_word;
  int          wait_n;
  logic        stuck;
  int          wr_cnt = 0;
  logic        waitrequest;

  logic        avm_address_a, avm_read_a, busy_a, done_a, pass_a;
  logic        err_id_a, err_ts_a, err_timeout_a;
  logic [31:0] id_value_a, ts_value_a, readdata_a;
  logic [1:0]  state_a;
  logic        avm_address_b, avm_read_b, busy_b, done_b, pass_b;
  logic        err_id_b, err_ts_b, err_timeout_b;
  logic [31:0] id_value_b, ts_value_b, readdata_b;
  logic [1:0]  state_b;

  int checks = 0;
  int errors = 0;
  logic [3:0] hist [0:40];

  always #5 clock = ~clock;

  // Slave model: address 0 returns id_word, address 1 returns ts_word;
  // each read stalls wait_n cycles, or forever while stuck=1.
  assign readdata_a  = avm_address_a ? ts_word : id_word;
  assign readdata_b  = avm_address_b ? ts_word : id_word;
  assign waitrequest = avm_read_a && (stuck || (wr_cnt < wait_n));

  always @(posedge clock) begin
    if (!avm_read_a || !waitrequest) wr_cnt <= 0;
    else wr_cnt <= wr_cnt + 1;
  end

  sysid_read_master #(
    .CHECK_TIMESTAMP(1'b1),
    .TIMEOUT_CYCLES (4)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address_a), .avm_read(avm_read_a),
    .avm_readdata(readdata_a), .avm_waitrequest(waitrequest),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_id(err_id_a), .err_ts(err_ts_a), .err_timeout(err_timeout_a),
    .id_value(id_value_a), .ts_value(ts_value_a), .state_dbg(state_a)
  );

  sysid_read_master #(
    .CHECK_TIMESTAMP(1'b0),
    .TIMEOUT_CYCLES (4)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address_b), .avm_read(avm_read_b),
    .avm_readdata(readdata_b), .avm_waitrequest(waitrequest),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_id(err_id_b), .err_ts(err_ts_b), .err_timeout(err_timeout_b),
    .id_value(id_value_b), .ts_value(ts_value_b), .state_dbg(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status vector {busy, done, pass, err_id, err_ts, err_timeout}.
  task automatic check_dut(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b,
                           input logic [31:0] exp_id, input logic [31:0] exp_ts);
    check({tag, "_stat_a"}, {26'd0, busy_a, done_a, pass_a, err_id_a, err_ts_a, err_timeout_a}, {26'd0, exp_a});
    check({tag, "_stat_b"}, {26'd0, busy_b, done_b, pass_b, err_id_b, err_ts_b, err_timeout_b}, {26'd0, exp_b});
    check({tag, "_id_a"}, id_value_a, exp_id);
    check({tag, "_ts_a"}, ts_value_a, exp_ts);
    check({tag, "_id_b"}, id_value_b, exp_id);
    check({tag, "_ts_b"}, ts_value_b, exp_ts);
  endtask

  // Pulses start, then records {busy, done, avm_read, avm_address} after each
  // edge until done rises; hist[0] is the edge that samples start.
  task automatic run_seq(input string tag, input int exp_len, input int extra_at);
    int n;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    hist[0] = {busy_a, done_a, avm_read_a, avm_address_a};
    n = 0;
    while (n < 40 && !done_a) begin
      if (n == extra_at) begin
        @(negedge clock); start = 1'b1;
      end
      @(posedge clock); #1; start = 1'b0;
      n++;
      hist[n] = {busy_a, done_a, avm_read_a, avm_address_a};
    end
    check({tag, "_len"}, n, exp_len);
  endtask

  task automatic check_hist(input string tag, input int from, input int to, input logic [3:0] exp);
    for (int i = from; i <= to; i++) check($sformatf("%s_cyc%0d", tag, i), {28'd0, hist[i]}, {28'd0, exp});
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    id_word = 32'd0;
    ts_word = 32'd1380147445;
    wait_n  = 0;
    stuck   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_dut("rst", 6'b000000, 6'b000000, 32'd0, 32'd0);
    check("rst_read", {30'd0, avm_read_a, avm_read_b}, 32'd0);
    check("rst_state", {30'd0, state_a}, {30'd0, IDLE});

    // Zero-wait slave, matching values
    run_seq("zw", 3, -1);
    check_hist("zw", 0, 0, 4'b1010);
    check_hist("zw", 1, 1, 4'b1011);
    check_hist("zw", 2, 2, 4'b1000);
    check_hist("zw", 3, 3, 4'b0100);
    check_dut("zw", 6'b011000, 6'b011000, 32'd0, 32'd1380147445);

    // Wrong ID
    id_word = 32'h0000_0001;
    run_seq("id", 3, -1);
    check_dut("id", 6'b010100, 6'b010100, 32'd1, 32'd1380147445);
    id_word = 32'd0;

    // Wrong timestamp: only the checking instance fails
    ts_word = 32'h1234_5678;
    run_seq("ts", 3, -1);
    check_dut("ts", 6'b010010, 6'b011010, 32'd0, 32'h1234_5678);
    ts_word = 32'd1380147445;

    // Three stall cycles per read, with a start while busy
    wait_n = 3;
    run_seq("ws", 9, 2);
    check_hist("ws", 0, 3, 4'b1010);
    check_hist("ws", 4, 7, 4'b1011);
    check_hist("ws", 8, 8, 4'b1000);
    check_hist("ws", 9, 9, 4'b0100);
    check_dut("ws", 6'b011000, 6'b011000, 32'd0, 32'd1380147445);
    repeat (3) @(posedge clock);
    #1;
    check("ws_no_queue", {31'd0, busy_a}, 32'd0);
    wait_n = 0;

    // Start held across the done edge: ignored in FINISH, accepted next edge
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    check("bnd_finish", {30'd0, busy_a, done_a}, 32'd1);
    @(posedge clock); #1; start = 1'b0;
    check("bnd_accept", {30'd0, busy_a, done_a}, 32'd2);
    for (int i = 0; i < 20 && !done_a; i++) begin
      @(posedge clock); #1;
    end
    check_dut("bnd", 6'b011000, 6'b011000, 32'd0, 32'd1380147445);

    // Stuck slave with TIMEOUT_CYCLES=4
    stuck = 1'b1;
    run_seq("to", 6, -1);
    check_hist("to", 0, 4, 4'b1010);
    check_hist("to", 5, 5, 4'b1000);
    check_hist("to", 6, 6, 4'b0100);
    check_dut("to", 6'b010001, 6'b010001, 32'd0, 32'd0);
    stuck = 1'b0;

    // Reset while stalled in RD_TS, with start in the reset cycle
    wait_n  = 3;
    id_word = 32'h55;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_state", {30'd0, state_a}, {30'd0, RD_TS});
    check("mid_id", id_value_a, 32'h55);
    @(negedge clock); reset = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    check_dut("mid_rst", 6'b000000, 6'b000000, 32'd0, 32'd0);
    check("mid_rst_read", {30'd0, avm_read_a, avm_read_b}, 32'd0);
    @(negedge clock); reset = 1'b0; start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("mid_idle", {29'd0, busy_a, state_a}, {29'd0, 1'b0, IDLE});
    wait_n  = 0;
    id_word = 32'd0;
    run_seq("clean", 3, -1);
    check_dut("clean", 6'b011000, 6'b011000, 32'd0, 32'd1380147445);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
